// File: rtl/bip_datapath.sv
// BIP core datapath: 16-bit accumulator, add/subtract ALU and registered Zero/Negative flags.
// Define DATAPATH_EXT_OUT_EN to expose the sign-extended operand on ext_out.
module bip_datapath #(
  parameter int OPERAND_WIDTH = 11,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clock_in,
  input  logic                     acc_reset_in,
  input  logic                     status_reset_in,
  input  logic [OPERAND_WIDTH-1:0] operand_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     alu_op_in,
  input  logic [1:0]               sel_A_in,
  input  logic                     sel_B_in,
  input  logic                     acc_wr_in,
  input  logic                     status_wr_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [OPERAND_WIDTH-1:0] data_address_out,
  output logic                     status_Z_out,
`ifdef DATAPATH_EXT_OUT_EN
  output logic                     status_N_out,
  output logic [DATA_WIDTH-1:0]    ext_out
`else
  output logic                     status_N_out
`endif
);

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] ext;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] acc_next;
  logic                  flag_z;
  logic                  flag_n;

  // Signed cast then resize replicates the operand MSB, and stays legal when the widths are equal.
  assign ext = DATA_WIDTH'($signed(operand_in));

  always_comb begin
    operand_b = sel_B_in ? ext : data_in;
    alu_result = alu_op_in ? (acc - operand_b) : (acc + operand_b);
    acc_next = acc;
    unique case (sel_A_in)
      2'b00:   acc_next = data_in;
      2'b01:   acc_next = ext;
      2'b10:   acc_next = alu_result;
      default: acc_next = acc;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (acc_reset_in) begin
      acc <= '0;
    end else if (acc_wr_in) begin
      acc <= acc_next;
    end
  end

  // Flags track the ALU result of this cycle, not whatever gets loaded into ACC.
  always_ff @(posedge clock_in) begin
    if (status_reset_in) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (status_wr_in) begin
      flag_z <= (alu_result == '0);
      flag_n <= alu_result[DATA_WIDTH-1];
    end
  end

  assign data_out         = acc;
  assign data_address_out = operand_in;
  assign status_Z_out     = flag_z;
  assign status_N_out     = flag_n;
`ifdef DATAPATH_EXT_OUT_EN
  assign ext_out          = ext;
`endif

endmodule

// File: tb/tb_bip_datapath.sv
// Scoreboard bench for bip_datapath: directed vectors push expected ACC/flags/address,
// a monitor pops and compares one entry after every rising edge.
module tb_bip_datapath;

  logic        clock_in = 1'b0;
  logic        acc_reset_in = 1'b0;
  logic        status_reset_in = 1'b0;
  logic [10:0] operand_in = '0;
  logic [15:0] data_in = '0;
  logic        alu_op_in = 1'b0;
  logic [1:0]  sel_A_in = 2'b11;
  logic        sel_B_in = 1'b0;
  logic        acc_wr_in = 1'b0;
  logic        status_wr_in = 1'b0;
  logic [15:0] data_out;
  logic [10:0] data_address_out;
  logic        status_Z_out;
  logic        status_N_out;
`ifdef DATAPATH_EXT_OUT_EN
  logic [15:0] ext_out;
`endif

  typedef struct {
    string       name;
    logic [15:0] acc;
    logic        z;
    logic        n;
    logic [10:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bip_datapath #(.OPERAND_WIDTH(11), .DATA_WIDTH(16)) dut (
    .clock_in(clock_in),
    .acc_reset_in(acc_reset_in),
    .status_reset_in(status_reset_in),
    .operand_in(operand_in),
    .data_in(data_in),
    .alu_op_in(alu_op_in),
    .sel_A_in(sel_A_in),
    .sel_B_in(sel_B_in),
    .acc_wr_in(acc_wr_in),
    .status_wr_in(status_wr_in),
    .data_out(data_out),
    .data_address_out(data_address_out),
    .status_Z_out(status_Z_out),
`ifdef DATAPATH_EXT_OUT_EN
    .status_N_out(status_N_out),
    .ext_out(ext_out)
`else
    .status_N_out(status_N_out)
`endif
  );

  always #5 clock_in = ~clock_in;

  // Monitor: every rising edge produces one observable result.
  always @(posedge clock_in) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (data_out !== e.acc) begin
        errors++;
        $display("FAIL %s acc: got %h expected %h", e.name, data_out, e.acc);
      end
      checks++;
      if (status_Z_out !== e.z) begin
        errors++;
        $display("FAIL %s Z: got %b expected %b", e.name, status_Z_out, e.z);
      end
      checks++;
      if (status_N_out !== e.n) begin
        errors++;
        $display("FAIL %s N: got %b expected %b", e.name, status_N_out, e.n);
      end
      checks++;
      if (data_address_out !== e.addr) begin
        errors++;
        $display("FAIL %s addr: got %h expected %h", e.name, data_address_out, e.addr);
      end
    end
  end

  task automatic step(input string nm, input logic ar, input logic sr,
                      input logic [10:0] op, input logic [15:0] din, input logic alu,
                      input logic [1:0] sa, input logic sb, input logic aw, input logic sw,
                      input logic [15:0] e_acc, input logic e_z, input logic e_n);
    exp_t e;
    @(negedge clock_in);
    acc_reset_in    = ar;
    status_reset_in = sr;
    operand_in      = op;
    data_in         = din;
    alu_op_in       = alu;
    sel_A_in        = sa;
    sel_B_in        = sb;
    acc_wr_in       = aw;
    status_wr_in    = sw;
    e.name = nm;
    e.acc  = e_acc;
    e.z    = e_z;
    e.n    = e_n;
    e.addr = op;
    exp_q.push_back(e);
  endtask

  initial begin
    //    name          ar    sr    operand  data_in   alu   selA   selB  acc_wr st_wr  exp_acc   Z     N
    step("reset",       1'b1, 1'b1, 11'h000, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step("load_mem",    1'b0, 1'b0, 11'h000, 16'h0001, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    step("load_imm2",   1'b0, 1'b0, 11'h002, 16'h0000, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
    step("load_imm7ff", 1'b0, 1'b0, 11'h7FF, 16'h0000, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    step("load_imm2b",  1'b0, 1'b0, 11'h002, 16'h0000, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
    step("add_mem",     1'b0, 1'b0, 11'h010, 16'h0001, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b0);
    step("sub_zero",    1'b0, 1'b0, 11'h010, 16'h0003, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    step("sub_neg",     1'b0, 1'b0, 11'h005, 16'h0003, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 16'hFFFB, 1'b0, 1'b1);
    step("hold_no_wr",  1'b0, 1'b0, 11'h123, 16'h1234, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'hFFFB, 1'b0, 1'b1);
    step("hold_selA11", 1'b0, 1'b0, 11'h456, 16'h5555, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 16'hFFFB, 1'b0, 1'b1);
    step("flags_only",  1'b0, 1'b0, 11'h001, 16'h0005, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'hFFFB, 1'b1, 1'b0);
    step("flags_preacc",1'b0, 1'b0, 11'h005, 16'h8000, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b0);
    step("add_neg",     1'b0, 1'b0, 11'h000, 16'h0001, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 16'h8001, 1'b0, 1'b1);
    step("st_reset",    1'b0, 1'b1, 11'h000, 16'h0001, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0);
    step("acc_reset",   1'b1, 1'b0, 11'h003, 16'h0000, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
    step("set_z",       1'b0, 1'b0, 11'h000, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    step("both_reset",  1'b1, 1'b1, 11'h004, 16'h7777, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
    step("load_7fff",   1'b0, 1'b0, 11'h000, 16'h7FFF, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    step("ovf_wrap",    1'b0, 1'b0, 11'h001, 16'h0000, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1);
    step("carry_wrap",  1'b0, 1'b0, 11'h000, 16'h8000, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    step("sub_imm_neg1",1'b0, 1'b0, 11'h7FF, 16'h0000, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock_in);
    @(negedge clock_in);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bip_datapath.md
Name: bip_datapath

Overview:
- Accumulator-based datapath of the BIP processor core: a 16-bit accumulator (ACC), an add/subtract ALU and Zero/Negative status flags.
- The control unit drives the mux selects, ALU op and write enables.
- The instruction operand doubles as the data-memory address; ACC drives the memory write-data bus.

Parameters:
- OPERAND_WIDTH, 11, instruction operand / data address width; must be ≤ DATA_WIDTH.
- DATA_WIDTH, 16, data path, ACC and memory word width.

Ports:
- clock_in  input  1  single system clock; all state updates on rising edge.
- acc_reset_in  input  1  synchronous active-high reset of ACC.
- status_reset_in  input  1  synchronous active-high reset of Z/N flags.
- operand_in  input  OPERAND_WIDTH  instruction operand (immediate or address).
- data_in  input  DATA_WIDTH  data-memory read word.
- alu_op_in  input  1  0 = add, 1 = subtract.
- sel_A_in  input  2  ACC write-source select.
- sel_B_in  input  1  ALU B-operand select.
- acc_wr_in  input  1  ACC write enable.
- status_wr_in  input  1  status flag write enable.
- data_out  output  DATA_WIDTH  current ACC value.
- data_address_out  output  OPERAND_WIDTH  data-memory address, equal to operand_in (combinational).
- status_Z_out  output  1  registered Zero flag.
- status_N_out  output  1  registered Negative flag.

Behaviour:
- ext = operand_in sign-extended to DATA_WIDTH (MSB replicated).
- B mux: sel_B_in=0 → data_in; 1 → ext.
- ALU (combinational), result modulo 2^DATA_WIDTH:
  - alu_op_in=0: ACC + B.
  - alu_op_in=1: ACC − B (two's complement).
  - Carry and overflow are discarded; no flag for either.
- A mux:
  - 00 → data_in.
  - 01 → ext.
  - 10 → ALU result.
  - 11 → current ACC (hold; write is effectively a no-op).
- ACC register, on rising edge:
  - acc_reset_in=1: ACC ← 0.
  - else if acc_wr_in=1: ACC ← A-mux value.
  - else hold.
- Status register, on rising edge:
  - status_reset_in=1: Z ← 0, N ← 0.
  - else if status_wr_in=1: Z ← (ALU result == 0), N ← ALU result[DATA_WIDTH−1].
  - Flags are computed from the pre-edge ACC and the current B, not from the value loaded into ACC.
- Simultaneous reset and write: reset wins.
- Resets are independent; status_wr_in is ignored while status_reset_in is high.
- Latency: one clock edge from inputs to ACC/flags. data_out reflects the new ACC right after the edge.
- data_address_out is purely combinational from operand_in, with zero latency.
- Reset values: data_out=0, status_Z_out=0, status_N_out=0.
- No storage other than ACC, Z and N. Output values before the first reset are don't-care.

Optional Feature:
- Macro DATAPATH_EXT_OUT_EN.
- When defined: adds output port ext_out (DATA_WIDTH) carrying the sign-extended operand (ext), combinational, for debug and branch-target use.
- When undefined: the port is absent and behaviour is otherwise identical.

Test Plan:
- Reset then load memory: both resets high for 1 edge → data_out=0, Z=N=0. Then data_in=1, sel_A=00, acc_wr=1, one edge → data_out=1.
- Immediate load: operand=2, sel_A=01, acc_wr=1 → data_out=2, data_address_out=2. operand=11'h7FF → data_out=16'hFFFF (sign extension).
- Add with flags: ACC=2, data_in=1, sel_B=0, alu_op=0, sel_A=10, acc_wr=1, status_wr=1 → data_out=3, Z=0, N=0.
- Subtract to zero/negative:
  - ACC=3, data_in=3, alu_op=1, sel_A=10, status_wr=1 → ACC=0, Z=1, N=0.
  - Next edge with operand=5, sel_B=1 → ACC=16'hFFFB, Z=0, N=1.
- Write-enable gating: acc_wr=0, status_wr=0 with changing inputs → ACC and flags hold. sel_A=11 with acc_wr=1 → ACC unchanged.
- Reset priority: acc_reset=1 with acc_wr=1, and status_reset=1 with status_wr=1 on the same edge → ACC=0, Z=N=0. Asserting only status_reset leaves ACC intact.
